kbd_if: RTL and testbench

KBD_IF -- requirements
Module: kbd_if

---
 rtl/kbd_if.sv | 149 ++++++++++++++
 tb/tb_kbd_if.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/kbd_if.sv
// PS/2 keyboard front end: filtered receiver, scan-code decode, 4-key buffer.
// Define KBD_IF_PARITY_CHECK_EN to reject frames with bad odd parity.
module kbd_if #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk256,
  input  logic        reset,
  input  logic        shift,
  input  logic        PS2C,
  input  logic        PS2D,
  output logic [31:0] key_buffer,
  output logic [7:0]  key,
  output logic        set_alarm,
  output logic        set_time
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    c_sync_q, d_sync_q;
  logic [FW-1:0] flt_cnt_q;
  logic          flt_q, strobe_q;
  logic [3:0]    bit_q;
  logic [9:0]    sh_q;
  logic [TW-1:0] to_q;
  logic          vld_q, brk_q;
  logic [7:0]    byte_q;
  logic          flt_fall, frame_ok, par_ok;
  logic [7:0]    digit;

  assign flt_fall = flt_q & ~c_sync_q[1] & (flt_cnt_q == FLT_LAST);

`ifdef KBD_IF_PARITY_CHECK_EN
  assign par_ok = ^sh_q[9:1];
`else
  assign par_ok = 1'b1;
`endif

  // sh_q[0] is the start bit, sh_q[9] parity; the stop bit is live on d_sync_q
  assign frame_ok = ~sh_q[0] & d_sync_q[1] & par_ok;

  always_comb begin
    digit = 8'h00;
    case (byte_q)
      8'h45:   digit = 8'h30;
      8'h16:   digit = 8'h31;
      8'h1E:   digit = 8'h32;
      8'h26:   digit = 8'h33;
      8'h25:   digit = 8'h34;
      8'h2E:   digit = 8'h35;
      8'h36:   digit = 8'h36;
      8'h3D:   digit = 8'h37;
      8'h3E:   digit = 8'h38;
      8'h46:   digit = 8'h39;
      default: digit = 8'h00;
    endcase
  end

  always_ff @(posedge clk256 or negedge reset) begin
    if (!reset) begin
      c_sync_q  <= 2'b11;
      d_sync_q  <= 2'b11;
      flt_q     <= 1'b1;
      flt_cnt_q <= '0;
      strobe_q  <= 1'b0;
    end else begin
      c_sync_q <= {c_sync_q[0], PS2C};
      d_sync_q <= {d_sync_q[0], PS2D};
      strobe_q <= flt_fall;
      if (c_sync_q[1] == flt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FLT_LAST) begin
        flt_q     <= c_sync_q[1];
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk256 or negedge reset) begin
    if (!reset) begin
      bit_q  <= '0;
      sh_q   <= '0;
      to_q   <= '0;
      vld_q  <= 1'b0;
      byte_q <= '0;
    end else begin
      vld_q <= 1'b0;
      if (strobe_q) begin
        to_q <= '0;
        if (bit_q == 4'd10) begin
          bit_q <= '0;
          if (frame_ok) begin
            vld_q  <= 1'b1;
            byte_q <= sh_q[8:1];
          end
        end else begin
          bit_q <= bit_q + 4'd1;
          sh_q  <= {d_sync_q[1], sh_q[9:1]};
        end
      end else if (bit_q != 4'd0) begin
        if (to_q == TO_LAST) begin
          bit_q <= '0;
          to_q  <= '0;
        end else begin
          to_q <= to_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk256 or negedge reset) begin
    if (!reset) begin
      key_buffer <= '0;
      key        <= '0;
      set_alarm  <= 1'b0;
      set_time   <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      set_alarm <= 1'b0;
      set_time  <= 1'b0;
      if (shift && key != 8'h00) begin
        key_buffer <= {key_buffer[23:0], key};
        key        <= 8'h00;
      end
      // a digit decoded here wins over the clear from the shift above
      if (vld_q) begin
        if (byte_q == 8'hE0) begin
          brk_q <= brk_q;
        end else if (byte_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else if (brk_q) begin
          brk_q <= 1'b0;
        end else if (byte_q == 8'h1C) begin
          set_alarm <= 1'b1;
        end else if (byte_q == 8'h2C) begin
          set_time <= 1'b1;
        end else if (digit != 8'h00) begin
          key <= digit;
        end
      end
    end
  end

endmodule

// File: tb/tb_kbd_if.sv
// Bench for kbd_if: scan-code table plus timeout, parity and reset sequences.
module tb_kbd_if;

  logic        clk = 1'b0;
  logic        rst_n, shift, ps2c, ps2d;
  logic [31:0] kbuf;
  logic [7:0]  key;
  logic        sa, st;

  always #5 clk = ~clk;

  kbd_if #(.FILTER_LEN(8), .TIMEOUT_CYCLES(512)) dut (
    .clk256(clk), .reset(rst_n), .shift(shift), .PS2C(ps2c), .PS2D(ps2d),
    .key_buffer(kbuf), .key(key), .set_alarm(sa), .set_time(st)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } ev_t;
  ev_t evq[$];

  typedef struct {
    logic [7:0]  code;
    bit          sh;
    logic [7:0]  k;
    logic [31:0] buf_exp;
    int          ev;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic got(input int kind, input logic [7:0] val);
    ev_t e;
    if (evq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event act=%0d/%h exp=none", kind, val);
    end else begin
      e = evq.pop_front();
      chk("ev_kind", 32'(kind), 32'(e.kind));
      chk("ev_val", 32'(val), 32'(e.val));
    end
  endtask

  task automatic push(input int kind, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    evq.push_back(e);
  endtask

  logic [7:0] pkey = 8'h00;
  logic       psa = 1'b0, pst = 1'b0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (key !== pkey && key !== 8'h00) got(1, key);
      if (sa === 1'b1) begin
        chk("alarm_width", 32'(psa), 32'd0);
        got(2, 8'h00);
      end
      if (st === 1'b1) begin
        chk("time_width", 32'(pst), 32'd0);
        got(3, 8'h00);
      end
    end
    pkey = key;
    psa  = sa;
    pst  = st;
  end

  task automatic send(input logic [7:0] b, input bit badpar, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ badpar, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = f[i];
      repeat (20) @(negedge clk);
      ps2c = 1'b0;
      repeat (20) @(negedge clk);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    repeat (60) @(negedge clk);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_buf"}, kbuf, 32'h0);
    chk({nm, "_key"}, 32'(key), 32'h0);
    chk({nm, "_alarm"}, 32'(sa), 32'h0);
    chk({nm, "_time"}, 32'(st), 32'h0);
  endtask

  logic [7:0] kp;

  initial begin
    tbl[0]  = '{8'h16, 1'b1, 8'h31, 32'h00000031, 1};
    tbl[1]  = '{8'h1E, 1'b1, 8'h32, 32'h00003132, 1};
    tbl[2]  = '{8'h26, 1'b1, 8'h33, 32'h00313233, 1};
    tbl[3]  = '{8'h25, 1'b1, 8'h34, 32'h31323334, 1};
    tbl[4]  = '{8'h2E, 1'b1, 8'h35, 32'h32333435, 1};
    tbl[5]  = '{8'hF0, 1'b0, 8'h00, 32'h32333435, 0};
    tbl[6]  = '{8'h16, 1'b0, 8'h00, 32'h32333435, 0};
    tbl[7]  = '{8'h1C, 1'b0, 8'h00, 32'h32333435, 2};
    tbl[8]  = '{8'h2C, 1'b0, 8'h00, 32'h32333435, 3};
    tbl[9]  = '{8'hE0, 1'b0, 8'h00, 32'h32333435, 0};
    tbl[10] = '{8'h45, 1'b1, 8'h30, 32'h33343530, 1};
    tbl[11] = '{8'hE0, 1'b0, 8'h00, 32'h33343530, 0};
    tbl[12] = '{8'hF0, 1'b0, 8'h00, 32'h33343530, 0};
    tbl[13] = '{8'h3D, 1'b0, 8'h00, 32'h33343530, 0};
    tbl[14] = '{8'h3E, 1'b0, 8'h38, 32'h33343530, 1};
    tbl[15] = '{8'h46, 1'b0, 8'h39, 32'h33343530, 1};
    tbl[16] = '{8'h12, 1'b1, 8'h39, 32'h34353039, 0};
    tbl[17] = '{8'hE0, 1'b1, 8'h00, 32'h34353039, 0};

    rst_n = 1'b0;
    shift = 1'b0;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    repeat (5) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk_idle("idle");

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].ev != 0)
        push(tbl[i].ev, (tbl[i].ev == 1) ? tbl[i].k : 8'h00);
      send(tbl[i].code, 1'b0, 11);
      chk($sformatf("key_%0d", i), 32'(key), 32'(tbl[i].k));
      if (i == 0) begin
        repeat (200) @(negedge clk);
        chk("key_hold", 32'(key), 32'(tbl[i].k));
      end
      if (tbl[i].sh) begin
        shift = 1'b1;
        @(negedge clk);
        shift = 1'b0;
        @(negedge clk);
        chk($sformatf("key_clr_%0d", i), 32'(key), 32'h0);
      end
      chk($sformatf("buf_%0d", i), kbuf, tbl[i].buf_exp);
    end

    send(8'h1C, 1'b0, 5);
    repeat (600) @(negedge clk);
    push(1, 8'h30);
    send(8'h45, 1'b0, 11);
    chk("timeout_key", 32'(key), 32'h30);

`ifdef KBD_IF_PARITY_CHECK_EN
    kp = 8'h30;
`else
    kp = 8'h31;
    push(1, 8'h31);
`endif
    send(8'h16, 1'b1, 11);
    chk("parity_key", 32'(key), 32'(kp));

    shift = 1'b1;
    push(1, 8'h32);
    send(8'h1E, 1'b0, 11);
    shift = 1'b0;
    @(negedge clk);
    chk("shift_held_key", 32'(key), 32'h0);
    chk("shift_held_buf", kbuf, {16'h3039, kp, 8'h32});

    send(8'h2C, 1'b0, 5);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("midreset");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    push(1, 8'h30);
    send(8'h45, 1'b0, 11);
    chk("post_reset_key", 32'(key), 32'h30);

    repeat (20) @(negedge clk);
    chk("evq_empty", 32'(evq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
